obi_mem_arbiter: RTL and testbench

//  N-to-1 OBI-style arbiter merging 32-bit requesters (scalar instr/data, vector LSU) onto one MEM_W-wide memory port.

---
 rtl/obi_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// N-to-1 OBI arbiter onto a MEM_W-wide memory port. An in-order FIFO of {port, lane, we}
// routes each downstream response back to the requester that issued it.
module obi_mem_arbiter_rsp #(
  parameter int MEM_W   = 32,
  parameter int LW      = 1,
  parameter int IDX_W   = 1,
  parameter int P       = 0,
  parameter bit NO_WRSP = 1'b0
) (
  input  logic             i_pop,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [LW-1:0]    i_lane,
  input  logic             i_we,
  input  logic [MEM_W-1:0] i_rdata,
  input  logic             i_err,
  output logic             o_rvalid,
  output logic             o_err,
  output logic [31:0]      o_rdata
);
  logic w_sel;

  // Swallowed write responses still pop the FIFO but never reach this port.
  assign w_sel    = i_pop && (i_idx == IDX_W'(P)) && !(i_we && NO_WRSP);
  assign o_rvalid = w_sel;
  assign o_err    = w_sel & i_err;
  assign o_rdata  = w_sel ? i_rdata[32*i_lane +: 32] : '0;
endmodule

module obi_mem_arbiter #(
  parameter int                   NUM_PORTS    = 2,
  parameter int                   MEM_W        = 32,
  parameter int                   DEPTH        = 8,
  parameter bit                   RR_EN        = 1'b0,
  parameter logic [NUM_PORTS-1:0] NO_WRSP_MASK = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_PORTS-1:0]      req_i,
  output logic [NUM_PORTS-1:0]      gnt_o,
  input  logic [NUM_PORTS*32-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]      we_i,
  input  logic [NUM_PORTS*4-1:0]    be_i,
  input  logic [NUM_PORTS*32-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]      rvalid_o,
  output logic [NUM_PORTS*32-1:0]   rdata_o,
  output logic [NUM_PORTS-1:0]      err_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [31:0]               mem_addr_o,
  output logic                      mem_we_o,
  output logic [MEM_W/8-1:0]        mem_be_o,
  output logic [MEM_W-1:0]          mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [MEM_W-1:0]          mem_rdata_i,
  input  logic                      mem_err_i,
  output logic [$clog2(DEPTH):0]    outstanding_o,
  output logic                      spurious_o
);
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BE_W  = MEM_W / 8;
  localparam int LW    = (MEM_W > 32) ? $clog2(MEM_W / 32) : 1;
  localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [LW-1:0]    lane;
    logic             we;
  } ent_t;

  ent_t             r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_cnt;
  logic [IDX_W-1:0] r_rr_ptr;

  logic             w_found, w_can, w_hs, w_pop, w_we;
  logic [IDX_W-1:0] w_win;
  logic [LW-1:0]    w_lane;
  logic [31:0]      w_addr, w_wdata;
  logic [3:0]       w_be;
  ent_t             w_head, w_push_ent;

  // Candidate at search offset `off`; round-robin rotates the search origin to r_rr_ptr.
  function automatic logic [IDX_W-1:0] f_cand(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = RR_EN ? int'(base) + off : off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_W'(s);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && req_i[f_cand(r_rr_ptr, i)]) begin
        w_found = 1'b1;
        w_win   = f_cand(r_rr_ptr, i);
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_be    = '0;
    w_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_win == IDX_W'(p)) begin
        w_addr  = addr_i[32*p +: 32];
        w_we    = we_i[p];
        w_be    = be_i[4*p +: 4];
        w_wdata = wdata_i[32*p +: 32];
      end
    end
  end

  if (MEM_W > 32) begin : g_lane
    assign w_lane = w_addr[LW+1:2];
  end else begin : g_nolane
    assign w_lane = '0;
  end

  // A response in the same cycle frees a slot, so a full FIFO may still accept.
  assign w_can     = rst_ni && ((r_cnt != CNT_FULL) || mem_rvalid_i);
  assign mem_req_o = w_found && w_can;
  assign w_hs      = mem_req_o && mem_gnt_i;
  assign w_pop     = mem_rvalid_i && (r_cnt != '0);
  assign spurious_o = rst_ni && mem_rvalid_i && (r_cnt == '0);

  always_comb begin
    gnt_o        = '0;
    gnt_o[w_win] = w_hs;
  end

  assign mem_addr_o    = w_addr;
  assign mem_we_o      = w_we;
  assign mem_be_o      = BE_W'(w_be) << {w_lane, 2'b00};
  assign mem_wdata_o   = {(MEM_W/32){w_wdata}};
  assign outstanding_o = r_cnt;

  assign w_push_ent = '{idx: w_win, lane: w_lane, we: w_we};
  assign w_head     = r_fifo[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_hs) r_fifo[r_wptr] <= w_push_ent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_hs)  r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_hs && RR_EN)
        r_rr_ptr <= (w_win == IDX_W'(NUM_PORTS-1)) ? '0 : w_win + IDX_W'(1);
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    obi_mem_arbiter_rsp #(
      .MEM_W(MEM_W), .LW(LW), .IDX_W(IDX_W), .P(p), .NO_WRSP(NO_WRSP_MASK[p])
    ) u_rsp (
      .i_pop   (w_pop),
      .i_idx   (w_head.idx),
      .i_lane  (w_head.lane),
      .i_we    (w_head.we),
      .i_rdata (mem_rdata_i),
      .i_err   (mem_err_i),
      .o_rvalid(rvalid_o[p]),
      .o_err   (err_o[p]),
      .o_rdata (rdata_o[32*p +: 32])
    );

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i[p] && !gnt_o[p]) ##1 req_i[p] |->
        $stable(addr_i[32*p +: 32]) && $stable(we_i[p]) &&
        $stable(be_i[4*p +: 4]) && $stable(wdata_i[32*p +: 32]));
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench: instance A (2 ports, 128-bit, depth 4, fixed prio, port1 write-rsp masked)
// and instance B (3 ports, 32-bit, depth 8, round-robin).
module tb_obi_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tot = 0, n_pass = 0, n_fail = 0;

  // Instance A
  logic [1:0]   a_req, a_gnt, a_we, a_rvalid, a_err;
  logic [63:0]  a_addr, a_wdata, a_rdata;
  logic [7:0]   a_be;
  logic         a_mem_req, a_mem_gnt, a_mem_we, a_mem_rvalid, a_mem_err, a_spur;
  logic [31:0]  a_mem_addr;
  logic [15:0]  a_mem_be;
  logic [127:0] a_mem_wdata, a_mem_rdata;
  logic [2:0]   a_out;

  // Instance B
  logic [2:0]   b_req, b_gnt, b_we, b_rvalid, b_err;
  logic [95:0]  b_addr, b_wdata, b_rdata;
  logic [11:0]  b_be;
  logic         b_mem_req, b_mem_gnt, b_mem_we, b_mem_rvalid, b_mem_err, b_spur;
  logic [31:0]  b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]   b_mem_be;
  logic [3:0]   b_out;

  logic [2:0] exp_rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  obi_mem_arbiter #(.NUM_PORTS(2), .MEM_W(128), .DEPTH(4), .RR_EN(1'b0), .NO_WRSP_MASK(2'b10)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .we_i(a_we),
    .be_i(a_be), .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err),
    .mem_req_o(a_mem_req), .mem_gnt_i(a_mem_gnt), .mem_addr_o(a_mem_addr), .mem_we_o(a_mem_we),
    .mem_be_o(a_mem_be), .mem_wdata_o(a_mem_wdata), .mem_rvalid_i(a_mem_rvalid),
    .mem_rdata_i(a_mem_rdata), .mem_err_i(a_mem_err), .outstanding_o(a_out), .spurious_o(a_spur)
  );

  obi_mem_arbiter #(.NUM_PORTS(3), .MEM_W(32), .DEPTH(8), .RR_EN(1'b1), .NO_WRSP_MASK(3'b000)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr), .we_i(b_we),
    .be_i(b_be), .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err),
    .mem_req_o(b_mem_req), .mem_gnt_i(b_mem_gnt), .mem_addr_o(b_mem_addr), .mem_we_o(b_mem_we),
    .mem_be_o(b_mem_be), .mem_wdata_o(b_mem_wdata), .mem_rvalid_i(b_mem_rvalid),
    .mem_rdata_i(b_mem_rdata), .mem_err_i(b_mem_err), .outstanding_o(b_out), .spurious_o(b_spur)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0;
    a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = '0; a_mem_err = 1'b0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0;
    b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = '0; b_mem_err = 1'b0;

    // Reset: requests and a downstream response present, outputs must stay quiet
    a_req = 2'b11; a_mem_gnt = 1'b1; a_mem_rvalid = 1'b1;
    #1;
    chk("rst_gnt", a_gnt, 2'b00);
    chk("rst_mem_req", a_mem_req, 1'b0);
    chk("rst_rvalid", a_rvalid, 2'b00);
    chk("rst_err", a_err, 2'b00);
    chk("rst_spur", a_spur, 1'b0);
    chk("rst_occ_a", a_out, 3'd0);
    chk("rst_occ_b", b_out, 4'd0);
    repeat (2) @(negedge clk);
    a_req = 2'b00; a_mem_rvalid = 1'b0; rst_n = 1'b1;

    // Fixed priority: port0 wins every cycle until the FIFO fills
    a_addr = {32'h108, 32'h0}; a_be = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); a_req = 2'b11; #1;
      chk("fix_gnt", a_gnt, 2'b01);
      chk("fix_occ", a_out, c);
      chk("fix_be", a_mem_be, 16'h000F);
    end
    @(negedge clk); #1;
    chk("full_mem_req", a_mem_req, 1'b0);
    chk("full_gnt", a_gnt, 2'b00);
    chk("full_occ", a_out, 3'd4);
    // Response at full lets a new grant through in the same cycle
    @(negedge clk);
    a_mem_rvalid = 1'b1;
    a_mem_rdata = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    #1;
    chk("full_pp_gnt", a_gnt, 2'b01);
    chk("full_pp_rvalid", a_rvalid, 2'b01);
    chk("full_pp_rdata", a_rdata, {32'h0, 32'h1111_1111});
    @(negedge clk); a_req = 2'b00; a_mem_rvalid = 1'b0; #1;
    chk("full_pp_occ", a_out, 3'd4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); a_mem_rvalid = 1'b1; #1;
      chk("drain_rvalid", a_rvalid, 2'b01);
      chk("drain_occ", a_out, 4 - c);
    end
    @(negedge clk); #1;
    chk("spur_pulse", a_spur, 1'b1);
    chk("spur_rvalid", a_rvalid, 2'b00);
    chk("spur_occ", a_out, 3'd0);
    @(negedge clk); a_mem_rvalid = 1'b0; #1;
    chk("spur_clear", a_spur, 1'b0);
    chk("spur_occ2", a_out, 3'd0);

    // Lane steering, wdata replication, masked write responses
    @(negedge clk); a_req = 2'b10; a_addr = {32'h108, 32'hC}; a_we = 2'b00; a_be = 8'hFF; #1;
    chk("ln_gnt", a_gnt, 2'b10);
    chk("ln_addr", a_mem_addr, 32'h108);
    chk("ln_be", a_mem_be, 16'h0F00);
    chk("ln_we", a_mem_we, 1'b0);
    @(negedge clk);
    a_addr[63:32] = 32'h104; a_we = 2'b10; a_be[7:4] = 4'h3; a_wdata[63:32] = 32'hA5A5_0001;
    #1;
    chk("wr_gnt", a_gnt, 2'b10);
    chk("wr_we", a_mem_we, 1'b1);
    chk("wr_be", a_mem_be, 16'h0030);
    chk("wr_wdata", a_mem_wdata, {4{32'hA5A5_0001}});
    @(negedge clk); a_req = 2'b01; a_we = 2'b00; #1;
    chk("p0_gnt", a_gnt, 2'b01);
    chk("p0_be", a_mem_be, 16'hF000);
    @(negedge clk); a_req = 2'b00; a_mem_rvalid = 1'b1; a_mem_err = 1'b1; #1;
    chk("rsp1_rvalid", a_rvalid, 2'b10);
    chk("rsp1_err", a_err, 2'b10);
    chk("rsp1_rdata", a_rdata, {32'h3333_3333, 32'h0});
    chk("rsp1_occ", a_out, 3'd3);
    @(negedge clk); a_mem_err = 1'b0; #1;
    chk("rsp2_swallow", a_rvalid, 2'b00);
    chk("rsp2_rdata", a_rdata, 64'h0);
    chk("rsp2_occ", a_out, 3'd2);
    @(negedge clk); #1;
    chk("rsp3_rvalid", a_rvalid, 2'b01);
    chk("rsp3_rdata", a_rdata, {32'h0, 32'h4444_4444});
    chk("rsp3_err", a_err, 2'b00);
    chk("rsp3_occ", a_out, 3'd1);
    @(negedge clk);
    a_mem_rvalid = 1'b0; a_req = 2'b01; a_we = 2'b01; a_addr[31:0] = 32'h0;
    #1;
    chk("p0wr_gnt", a_gnt, 2'b01);
    chk("p0wr_occ", a_out, 3'd0);
    @(negedge clk); a_req = 2'b00; a_we = 2'b00; a_mem_rvalid = 1'b1; #1;
    chk("p0wr_rvalid", a_rvalid, 2'b01);
    chk("p0wr_occ2", a_out, 3'd1);
    @(negedge clk); a_mem_rvalid = 1'b0;

    // Reset with transactions in flight
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); a_req = 2'b01;
    end
    @(negedge clk); #1;
    chk("mid_occ_pre", a_out, 3'd3);
    rst_n = 1'b0; #1;
    chk("mid_occ_rst", a_out, 3'd0);
    chk("mid_gnt_rst", a_gnt, 2'b00);
    chk("mid_req_rst", a_mem_req, 1'b0);
    @(negedge clk); a_req = 2'b00; rst_n = 1'b1; a_mem_rvalid = 1'b1; #1;
    chk("mid_late_spur", a_spur, 1'b1);
    chk("mid_late_rvalid", a_rvalid, 2'b00);
    @(negedge clk); a_mem_rvalid = 1'b0;

    // Round-robin: 0,1,2,0 then stall two cycles, then 1,2
    b_addr = {32'h300, 32'h200, 32'h100}; b_be = 12'hFFF; b_mem_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); b_req = 3'b111; #1;
      chk("rr_gnt", b_gnt, exp_rr[c]);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); b_mem_gnt = 1'b0; #1;
      chk("rr_hold_gnt", b_gnt, 3'b000);
      chk("rr_hold_req", b_mem_req, 1'b1);
      chk("rr_hold_addr", b_mem_addr, 32'h200);
    end
    @(negedge clk); b_mem_gnt = 1'b1; #1;
    chk("rr_resume1", b_gnt, 3'b010);
    @(negedge clk); #1;
    chk("rr_resume2", b_gnt, 3'b100);
    @(negedge clk); b_req = 3'b000; b_mem_rvalid = 1'b1; b_mem_rdata = 32'hCAFE_F00D; #1;
    chk("rr_rsp_rvalid", b_rvalid, 3'b001);
    chk("rr_rsp_rdata", b_rdata, {64'h0, 32'hCAFE_F00D});
    chk("rr_rsp_occ", b_out, 4'd6);
    @(negedge clk); b_mem_rvalid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
